// File: rtl/instr_type.sv
// rtl/instr_type.sv - store kinds, exception codes and decode helpers for the store unit
package instr_type;

  typedef enum logic [2:0] {
    sk_sb,
    sk_sh,
    sk_sw,
    sk_sd,
    sk_invalid
  } store_kind_t;

  typedef enum logic [1:0] {
    se_none,
    se_illegal,
    se_misaligned,
    se_access_fault
  } store_exc_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_RESP,
    ST_DONE
  } store_state_t;

  function automatic logic [3:0] store_size(input store_kind_t kind);
    case (kind)
      sk_sb:   return 4'd1;
      sk_sh:   return 4'd2;
      sk_sw:   return 4'd4;
      sk_sd:   return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  // SD only exists on a 64-bit datapath; elsewhere funct3=100 is illegal.
  function automatic store_kind_t decode_store(input logic [2:0] funct3, input logic sd_legal);
    case (funct3)
      3'b000:  return sk_sb;
      3'b010:  return sk_sh;
      3'b011:  return sk_sw;
      3'b100:  return sd_legal ? sk_sd : sk_invalid;
      default: return sk_invalid;
    endcase
  endfunction

endpackage

// File: rtl/store_align.sv
// rtl/store_align.sv - lane placement of store data/strobes and alignment check
module store_align
  import instr_type::*;
#(
  parameter int XLEN = 32,
  localparam int NB = XLEN / 8,
  localparam int OB = $clog2(NB)
) (
  input  logic [2:0]      kind,
  input  logic [OB-1:0]   addr,
  input  logic [XLEN-1:0] rs2_data,
  output logic [NB-1:0]   wstrb,
  output logic [XLEN-1:0] wdata,
  output logic            misaligned
);

  store_kind_t     k;
  logic [3:0]      size;
  logic [OB-1:0]   amask;
  logic [NB-1:0]   base_strb;
  logic [XLEN-1:0] base_data;

  always_comb begin
    k         = store_kind_t'(kind);
    size      = store_size(k);
    amask     = OB'(size - 4'd1);
    base_strb = '0;
    base_data = '0;
    case (k)
      sk_sb: begin
        base_strb[0]    = 1'b1;
        base_data[7:0]  = rs2_data[7:0];
      end
      sk_sh: begin
        base_strb[1:0]  = '1;
        base_data[15:0] = rs2_data[15:0];
      end
      sk_sw: begin
        base_strb[3:0]  = '1;
        base_data[31:0] = rs2_data[31:0];
      end
      sk_sd: begin
        base_strb = '1;
        base_data = rs2_data;
      end
      default: ;
    endcase
    // Accesses are never split, so any offset bit inside the access size is a fault.
    misaligned = (k != sk_invalid) && (|(addr & amask));
    wstrb      = base_strb << addr;
    wdata      = base_data << {addr, 3'b000};
  end

endmodule

// File: rtl/store_unit.sv
// rtl/store_unit.sv - sequential store unit: decode, align, memory handshake, timeout, completion
module store_unit
  import instr_type::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16,
  localparam int NB = XLEN / 8,
  localparam int OB = $clog2(NB)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] rs2_data,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [NB-1:0]   mem_wstrb,
  input  logic            mem_resp_valid,
  input  logic            mem_resp_err,
  output logic            out_valid,
  output logic [1:0]      out_exc
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  store_state_t    state_q;
  logic            in_ready_q;
  logic            mem_req_valid_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wdata_q;
  logic [NB-1:0]   mem_wstrb_q;
  logic            out_valid_q;
  store_exc_t      out_exc_q;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  store_kind_t     kind;
  logic [NB-1:0]   al_wstrb;
  logic [XLEN-1:0] al_wdata;
  logic            al_misaligned;

  assign kind  = decode_store(funct3, XLEN == 64);
  assign cnt_d = cnt_q + CW'(1);

  store_align #(
    .XLEN(XLEN)
  ) u_align (
    .kind      (kind),
    .addr      (addr[OB-1:0]),
    .rs2_data  (rs2_data),
    .wstrb     (al_wstrb),
    .wdata     (al_wdata),
    .misaligned(al_misaligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      in_ready_q      <= 1'b1;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wdata_q     <= '0;
      mem_wstrb_q     <= '0;
      out_valid_q     <= 1'b0;
      out_exc_q       <= se_none;
      cnt_q           <= '0;
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready_q <= 1'b0;
            if (kind == sk_invalid) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              out_exc_q   <= se_illegal;
            end else if (al_misaligned) begin
              state_q     <= ST_DONE;
              out_valid_q <= 1'b1;
              out_exc_q   <= se_misaligned;
            end else begin
              state_q         <= ST_REQ;
              mem_req_valid_q <= 1'b1;
              mem_addr_q      <= {addr[XLEN-1:OB], {OB{1'b0}}};
              mem_wdata_q     <= al_wdata;
              mem_wstrb_q     <= al_wstrb;
            end
          end
        end
        ST_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            state_q         <= ST_WAIT_RESP;
            cnt_q           <= '0;
          end
        end
        ST_WAIT_RESP: begin
          // A response in the same cycle as the timeout takes precedence.
          if (mem_resp_valid) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            out_exc_q   <= mem_resp_err ? se_access_fault : se_none;
          end else if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            out_exc_q   <= se_access_fault;
            cnt_q       <= cnt_d;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        ST_DONE: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b1;
          out_exc_q  <= se_none;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready      = in_ready_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wstrb     = mem_wstrb_q;
  assign out_valid     = out_valid_q;
  assign out_exc       = out_exc_q;

endmodule

// File: tb/tb_store_unit.sv
// tb/tb_store_unit.sv - scoreboard bench for store_unit at XLEN=32 and XLEN=64
module tb_store_unit;

  localparam int TO = 8;
  localparam logic [1:0] EXC_NONE  = 2'd0;
  localparam logic [1:0] EXC_ILL   = 2'd1;
  localparam logic [1:0] EXC_MIS   = 2'd2;
  localparam logic [1:0] EXC_FAULT = 2'd3;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel64 = 1'b0;
  logic        in_valid = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [63:0] addr = '0;
  logic [63:0] rs2 = '0;
  logic        mem_req_ready = 1'b0;
  logic        mem_resp_valid = 1'b0;
  logic        mem_resp_err = 1'b0;

  logic        iv32, iv64;
  logic        in_ready32, req_valid32, out_valid32;
  logic [31:0] maddr32, wdata32;
  logic [3:0]  wstrb32;
  logic [1:0]  exc32;
  logic        in_ready64, req_valid64, out_valid64;
  logic [63:0] maddr64, wdata64;
  logic [7:0]  wstrb64;
  logic [1:0]  exc64;

  logic        in_ready_m, req_valid_m, out_valid_m;
  logic [63:0] maddr_m, wdata_m;
  logic [7:0]  wstrb_m;
  logic [1:0]  exc_m;

  int    cyc = 0;
  int    n_vec = 0;
  int    n_fail = 0;
  int    out_cnt = 0;
  int    out_cyc = 0;
  beat_t beat_q[$];
  logic [1:0] exc_q[$];
  beat_t mon_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign iv32 = in_valid & ~sel64;
  assign iv64 = in_valid & sel64;

  store_unit #(.XLEN(32), .TIMEOUT_CYCLES(TO)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(in_ready32), .funct3(funct3),
    .addr(addr[31:0]), .rs2_data(rs2[31:0]), .mem_req_valid(req_valid32),
    .mem_req_ready(mem_req_ready), .mem_addr(maddr32), .mem_wdata(wdata32),
    .mem_wstrb(wstrb32), .mem_resp_valid(mem_resp_valid), .mem_resp_err(mem_resp_err),
    .out_valid(out_valid32), .out_exc(exc32)
  );

  store_unit #(.XLEN(64), .TIMEOUT_CYCLES(TO)) u_dut64 (
    .clk(clk), .rst(rst), .in_valid(iv64), .in_ready(in_ready64), .funct3(funct3),
    .addr(addr), .rs2_data(rs2), .mem_req_valid(req_valid64),
    .mem_req_ready(mem_req_ready), .mem_addr(maddr64), .mem_wdata(wdata64),
    .mem_wstrb(wstrb64), .mem_resp_valid(mem_resp_valid), .mem_resp_err(mem_resp_err),
    .out_valid(out_valid64), .out_exc(exc64)
  );

  always_comb begin
    if (sel64) begin
      in_ready_m  = in_ready64;
      req_valid_m = req_valid64;
      out_valid_m = out_valid64;
      maddr_m     = maddr64;
      wdata_m     = wdata64;
      wstrb_m     = wstrb64;
      exc_m       = exc64;
    end else begin
      in_ready_m  = in_ready32;
      req_valid_m = req_valid32;
      out_valid_m = out_valid32;
      maddr_m     = {32'd0, maddr32};
      wdata_m     = {32'd0, wdata32};
      wstrb_m     = {4'd0, wstrb32};
      exc_m       = exc32;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Reference: byte size from funct3, natural alignment, lanes chosen by address offset.
  function automatic void model(input bit x64, input logic [2:0] f3, input logic [63:0] a,
                                input logic [63:0] d, output logic [1:0] exc, output beat_t b);
    int size, nb, off;
    logic [127:0] m, wd;
    nb = x64 ? 8 : 4;
    case (f3)
      3'b000:  size = 1;
      3'b010:  size = 2;
      3'b011:  size = 4;
      3'b100:  size = x64 ? 8 : 0;
      default: size = 0;
    endcase
    b = '{addr: '0, data: '0, strb: '0};
    if (size == 0) exc = EXC_ILL;
    else if (a % 64'(size) != 0) exc = EXC_MIS;
    else begin
      exc    = EXC_NONE;
      off    = int'(a % 64'(nb));
      m      = (128'd1 << (8 * size)) - 128'd1;
      wd     = ({64'd0, d} & m) << (8 * off);
      b.addr = a - 64'(off);
      b.data = wd[63:0];
      b.strb = 8'(((1 << size) - 1) << off);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst && req_valid_m && mem_req_ready) begin
      if (beat_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_beat: got beat at addr %h, required none", maddr_m);
      end else begin
        mon_b = beat_q.pop_front();
        check("beat_addr", maddr_m, mon_b.addr);
        check("beat_wdata", wdata_m, mon_b.data);
        check("beat_wstrb", {56'd0, wstrb_m}, {56'd0, mon_b.strb});
      end
    end
    if (!rst && out_valid_m) begin
      out_cnt++;
      out_cyc = cyc;
      if (exc_q.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL unexpected_out: got out_valid exc %0d, required none", exc_m);
      end else begin
        check("out_exc", {62'd0, exc_m}, {62'd0, exc_q.pop_front()});
      end
    end
  end

  // rsdly >= TO means the memory never answers.
  task automatic do_store(input bit x64, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] d, input int rdly, input int rsdly, input logic err);
    logic [1:0] exc;
    beat_t b;
    int base, exp_cyc, h, k;
    model(x64, f3, a, d, exc, b);
    sel64 = x64;
    #1;
    check("in_ready_idle", {63'd0, in_ready_m}, 64'd1);
    base     = out_cnt;
    in_valid = 1'b1;
    funct3   = f3;
    addr     = a;
    rs2      = d;
    exp_cyc  = cyc + 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (exc != EXC_NONE) begin
      exc_q.push_back(exc);
    end else begin
      beat_q.push_back(b);
      exc_q.push_back((rsdly >= TO || err) ? EXC_FAULT : EXC_NONE);
      for (int i = 0; i < rdly; i++) begin
        @(negedge clk);
        check("hold_valid", {63'd0, req_valid_m}, 64'd1);
        check("hold_addr", maddr_m, b.addr);
        check("hold_wdata", wdata_m, b.data);
        check("hold_wstrb", {56'd0, wstrb_m}, {56'd0, b.strb});
        check("hold_in_ready", {63'd0, in_ready_m}, 64'd0);
        @(posedge clk); #1;
      end
      mem_req_ready = 1'b1;
      h = cyc;
      @(posedge clk); #1;
      mem_req_ready = 1'b0;
      if (rsdly < TO) begin
        repeat (rsdly) begin
          @(posedge clk); #1;
        end
        mem_resp_valid = 1'b1;
        mem_resp_err   = err;
        @(posedge clk); #1;
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
        exp_cyc = h + 2 + rsdly;
      end else begin
        exp_cyc = h + 1 + TO;
      end
    end
    k = 0;
    while (out_cnt == base && k < 40) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (out_cnt == base) begin
      n_vec++;
      n_fail++;
      $display("FAIL out_wait: got no out_valid, required one at cycle %0d", exp_cyc);
      exc_q.delete();
      beat_q.delete();
    end else begin
      check("out_cycle", 64'(out_cyc), 64'(exp_cyc));
    end
    check("beats_left", 64'(beat_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, {63'd0, in_ready_m}, 64'd1);
    check({tag, "_req_valid"}, {63'd0, req_valid_m}, 64'd0);
    check({tag, "_out_valid"}, {63'd0, out_valid_m}, 64'd0);
    check({tag, "_mem_addr"}, maddr_m, 64'd0);
    check({tag, "_mem_wdata"}, wdata_m, 64'd0);
    check({tag, "_mem_wstrb"}, {56'd0, wstrb_m}, 64'd0);
    check({tag, "_out_exc"}, {62'd0, exc_m}, 64'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no finish, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0]  exc;
    beat_t       b;
    int          base, r;
    bit          x64;
    logic [2:0]  f3, lo;
    logic [63:0] a;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst32");
    sel64 = 1'b1;
    #1;
    check_reset_outputs("rst64");
    sel64 = 1'b0;
    rst   = 1'b0;
    @(posedge clk); #1;

    do_store(0, 3'b000, 64'h1003, 64'hAABBCCDD, 0, 0, 1'b0);
    do_store(0, 3'b010, 64'h2002, 64'h1234CCDD, 0, 0, 1'b0);
    do_store(0, 3'b011, 64'h3001, 64'h11223344, 0, 0, 1'b0);
    do_store(0, 3'b001, 64'h4000, 64'h55, 0, 0, 1'b0);
    do_store(0, 3'b100, 64'h4008, 64'h66, 0, 0, 1'b0);
    do_store(0, 3'b010, 64'h5006, 64'hBEEF, 3, 1, 1'b0);
    do_store(0, 3'b011, 64'h6000, 64'hCAFEF00D, 0, TO, 1'b0);
    do_store(0, 3'b011, 64'h6004, 64'h01020304, 1, 0, 1'b1);
    do_store(0, 3'b000, 64'h6005, 64'h77, 0, TO - 1, 1'b0);

    model(0, 3'b000, 64'h44, 64'h5A, exc, b);
    sel64 = 1'b0;
    #1;
    beat_q.push_back(b);
    in_valid = 1'b1;
    funct3   = 3'b000;
    addr     = 64'h44;
    rs2      = 64'h5A;
    @(posedge clk); #1;
    in_valid      = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    rst  = 1'b0;
    base = out_cnt;
    mem_resp_valid = 1'b1;
    @(posedge clk); #1;
    mem_resp_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("stale_resp_out", 64'(out_cnt), 64'(base));
    check("midrst_beats_left", 64'(beat_q.size()), 64'd0);
    do_store(0, 3'b000, 64'h7001, 64'h12345678, 0, 0, 1'b0);

    do_store(1, 3'b100, 64'h8, 64'h0102030405060708, 0, 0, 1'b0);
    do_store(1, 3'b100, 64'hC, 64'h0102030405060708, 0, 0, 1'b0);
    do_store(1, 3'b011, 64'hC, 64'h0102030405060708, 0, 0, 1'b0);
    do_store(1, 3'b000, 64'h1F, 64'hFFFFFFFFFFFFFFA5, 2, 2, 1'b0);
    do_store(1, 3'b111, 64'h20, 64'h1, 0, 0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      x64 = 1'($urandom_range(0, 1));
      r   = $urandom_range(0, 9);
      case (r)
        0, 1:    f3 = 3'b000;
        2, 3:    f3 = 3'b010;
        4, 5:    f3 = 3'b011;
        6, 7:    f3 = 3'b100;
        default: f3 = 3'($urandom_range(0, 7));
      endcase
      lo = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0)
        lo = lo & ((f3 == 3'b010) ? 3'b110 : (f3 == 3'b011) ? 3'b100 :
                   (f3 == 3'b100) ? 3'b000 : 3'b111);
      a = {$urandom, $urandom};
      a[2:0] = lo;
      if (!x64) a[63:32] = '0;
      r = $urandom_range(0, 9);
      do_store(x64, f3, a, {$urandom, $urandom}, $urandom_range(0, 3),
               (r == 0) ? TO : (r == 1) ? TO - 1 : $urandom_range(0, 3),
               1'($urandom_range(0, 3) == 0));
    end

    check("final_exc_left", 64'(exc_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/store_unit.md
Name: store_unit

Overview:
- Sequential store execution unit for the core's memory stage, parametrised in XLEN (32 or 64).
- Decodes funct3 into store_kind_t and checks alignment.
- Produces an XLEN-wide aligned write beat with byte strobes and drives a valid/ready request to the data memory port.
- Waits for the memory response, with a timeout, and reports completion or an exception to writeback/trap logic.
- Successor to the combinational store decoder: adds width generality, SD, alignment, handshake and fault handling.

Parameters:
XLEN, 32, datapath/address width; legal values 32 or 64; SD is legal only when 64
TIMEOUT_CYCLES, 16, cycles waited in WAIT_RESP before an access fault; minimum 1
NB = XLEN/8 (localparam), byte lanes; OB = log2(NB) (localparam), offset bits

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  store request from pipeline
in_ready  out  1  unit can accept a request
funct3  in  3  store funct3
addr  in  XLEN  effective byte address
rs2_data  in  XLEN  store data, right-aligned
mem_req_valid  out  1  write request valid
mem_req_ready  in  1  memory accepts request
mem_addr  out  XLEN  addr with low OB bits cleared
mem_wdata  out  XLEN  lane-shifted data
mem_wstrb  out  NB  byte enables
mem_resp_valid  in  1  write response
mem_resp_err  in  1  response carries bus error
out_valid  out  1  one-cycle completion pulse
out_exc  out  2  store_exc_t: se_none, se_illegal, se_misaligned, se_access_fault

Behaviour:
- Reset: state IDLE, in_ready=1, mem_req_valid=0, out_valid=0, out_exc=se_none, mem_addr/mem_wdata/mem_wstrb=0, timeout counter=0. Reset takes effect immediately (asynchronous), including mid-request: mem_req_valid drops with no handshake.
- Decode: 000 SB (size 1); 010 SH (size 2); 011 SW (size 4); 100 SD (size 8, XLEN=64 only). All other encodings, and 100 when XLEN=32, decode to sk_invalid.
- Misaligned: addr mod size != 0. No misaligned access is ever split.
- Lane alignment: off = addr[OB-1:0].
  - mem_wstrb = ((1<<size)-1) << off.
  - mem_wdata = (rs2_data masked to size bytes) << (8*off). Unselected lanes are 0.
  - All outputs are registered.
- IDLE: in_ready=1. On in_valid, latch the request. Exceptions are checked in priority order, illegal before misaligned:
  - sk_invalid -> DONE with se_illegal.
  - misaligned -> DONE with se_misaligned.
  - otherwise -> REQ, payload registered.
- REQ: in_ready=0, mem_req_valid=1. Payload is held stable until mem_req_ready=1, at which point go to WAIT_RESP and clear the counter. mem_resp_valid is ignored in REQ.
- WAIT_RESP: mem_req_valid=0; counter increments each cycle.
  - mem_resp_valid -> DONE, with exc = mem_resp_err ? se_access_fault : se_none.
  - Counter reaching TIMEOUT_CYCLES with no response -> DONE with se_access_fault.
  - If a response and timeout occur in the same cycle, the response wins.
- DONE: out_valid=1 and out_exc valid for exactly one cycle, then IDLE. There is no backpressure on out.
- Latency, in_valid accepted at cycle 0:
  - Exception cases: out_valid at cycle 1; no mem request is issued.
  - Legal store with immediate ready and response one cycle later: mem_req_valid at 1, response at 2, out_valid at 3.
- Responses arriving in IDLE or DONE (stale, e.g. after reset) are ignored.
- in_ready is low from REQ through DONE. A new request is accepted no earlier than the cycle after out_valid.

Decomposition:
- Package instr_type:
  - extend store_kind_t with sk_sd;
  - add store_exc_t;
  - add a function mapping store_kind_t to a byte size.
- Sub-module store_align: combinational, parametrised by XLEN. Inputs kind, addr, rs2_data; outputs wstrb, wdata, misaligned.
- store_unit holds the FSM, registers and timeout counter.

Test Plan:
1. XLEN=32, SB at addr 0x1003, rs2 0xAABBCCDD, mem ready immediately, response next cycle with err=0 -> mem_addr 0x1000, wstrb 4'b1000, wdata 0xDD000000, out_valid at cycle 3 with se_none.
2. SH at addr 0x2002, rs2 0x1234CCDD -> wstrb 4'b1100, wdata 0xCCDD0000. Then SW at 0x3001 -> se_misaligned at cycle 1, mem_req_valid never asserted. Then funct3 3'b001 and 3'b100 -> se_illegal.
3. mem_req_ready held low 3 cycles -> mem_req_valid, mem_addr, wdata and wstrb unchanged over those cycles; in_ready=0 throughout; exactly one accepted beat.
4. TIMEOUT_CYCLES=8, no response -> out_valid with se_access_fault exactly 8 cycles after acceptance. Separately, a response with mem_resp_err=1 -> se_access_fault.
5. rst pulsed in WAIT_RESP -> outputs return to reset values immediately; a later stale mem_resp_valid produces no out_valid; next SB completes normally.
6. XLEN=64: SD at 0x8, rs2 0x0102030405060708 -> wstrb 8'hFF, full data; SD at 0xC -> se_misaligned; SW at 0xC -> wstrb 8'hF0, wdata 0x0506070800000000.
